// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC source encodings, hazard FSM states
// and the hard-wired zero register index.
package pipe_pkg;

    localparam logic [2:0] PCSRC_J_DEF  = 3'd2;
    localparam logic [2:0] PCSRC_JR_DEF = 3'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE    = 1'b0,
        JR_HOLD = 1'b1
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, clear (sync, wins over inc), inc, cnt (holds at all-ones).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use and jr-after-load detection, branch
// and jump flushes, plus saturating stall/flush performance counters.
// Ports: clk, reset (sync, active-high); ID sources IFID_rs/rt/UsesRt,
// ID_PCsrc; EX load IDEX_MemRd/IDEX_rt; MEM load EXMEM_MemRd/EXMEM_rdes;
// EX_BranchTaken. Outputs PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, Stall,
// stall_cnt, flush_cnt.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter logic [2:0] PCSRC_J  = PCSRC_J_DEF,
    parameter logic [2:0] PCSRC_JR = PCSRC_JR_DEF,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_UsesRt,
    input  logic [2:0]       ID_PCsrc,
    input  logic             IDEX_MemRd,
    input  logic [4:0]       IDEX_rt,
    input  logic             EXMEM_MemRd,
    input  logic [4:0]       EXMEM_rdes,
    input  logic             EX_BranchTaken,
    output logic             PC_Wr,
    output logic             IFID_Wr,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             Stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state, state_nxt;

    logic is_jr;
    logic is_jump;
    logic load_use;
    logic jr_load_ex;
    logic jr_load_mem;

    // $0 never carries a dependency, so every match requires a nonzero reg.
    assign is_jr   = (ID_PCsrc == PCSRC_JR) && (IFID_rs != REG_ZERO);
    assign is_jump = (ID_PCsrc == PCSRC_J) || (ID_PCsrc == PCSRC_JR);

    assign load_use = IDEX_MemRd && (IDEX_rt != REG_ZERO) &&
                      ((IDEX_rt == IFID_rs) ||
                       (IFID_UsesRt && (IDEX_rt == IFID_rt)));

    // jr resolves in ID, so it needs the value one stage earlier than
    // an ALU consumer: a load in EX costs two bubbles, in MEM one.
    assign jr_load_ex  = is_jr && IDEX_MemRd && (IDEX_rt == IFID_rs);
    assign jr_load_mem = is_jr && EXMEM_MemRd && (EXMEM_rdes == IFID_rs);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        PC_Wr      = 1'b1;
        IFID_Wr    = 1'b1;
        IFID_Flush = 1'b0;
        IDEX_Flush = 1'b0;
        Stall      = 1'b0;

        if (reset) begin
            state_nxt  = IDLE;
            PC_Wr      = 1'b0;
            IFID_Wr    = 1'b0;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (EX_BranchTaken) begin
            // Wrong-path instructions in IF and ID are discarded, which
            // also kills any jr being held.
            state_nxt  = IDLE;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (state == JR_HOLD) begin
            state_nxt  = IDLE;
            Stall      = 1'b1;
            PC_Wr      = 1'b0;
            IFID_Wr    = 1'b0;
            IDEX_Flush = 1'b1;
        end else if (jr_load_ex || jr_load_mem || load_use) begin
            if (jr_load_ex) begin
                state_nxt = JR_HOLD;
            end
            Stall      = 1'b1;
            PC_Wr      = 1'b0;
            IFID_Wr    = 1'b0;
            IDEX_Flush = 1'b1;
        end else if (is_jump) begin
            IFID_Flush = 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (Stall),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (IFID_Flush | IDEX_Flush),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and random stimulus against a behavioural model.
module tb_hazard_ctrl;

    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    IFID_rs = '0;
    logic [4:0]    IFID_rt = '0;
    logic          IFID_UsesRt = 1'b0;
    logic [2:0]    ID_PCsrc = '0;
    logic          IDEX_MemRd = 1'b0;
    logic [4:0]    IDEX_rt = '0;
    logic          EXMEM_MemRd = 1'b0;
    logic [4:0]    EXMEM_rdes = '0;
    logic          EX_BranchTaken = 1'b0;
    logic          PC_Wr;
    logic          IFID_Wr;
    logic          IFID_Flush;
    logic          IDEX_Flush;
    logic          Stall;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .IFID_rs        (IFID_rs),
        .IFID_rt        (IFID_rt),
        .IFID_UsesRt    (IFID_UsesRt),
        .ID_PCsrc       (ID_PCsrc),
        .IDEX_MemRd     (IDEX_MemRd),
        .IDEX_rt        (IDEX_rt),
        .EXMEM_MemRd    (EXMEM_MemRd),
        .EXMEM_rdes     (EXMEM_rdes),
        .EX_BranchTaken (EX_BranchTaken),
        .PC_Wr          (PC_Wr),
        .IFID_Wr        (IFID_Wr),
        .IFID_Flush     (IFID_Flush),
        .IDEX_Flush     (IDEX_Flush),
        .Stall          (Stall),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [2:0] pcsrc;
        logic       ex_ld;
        logic [4:0] ex_rt;
        logic       mem_ld;
        logic [4:0] mem_rd;
        logic       br;
    } in_t;

    typedef struct {
        in_t        i;
        logic [4:0] exp;
    } vec_t;

    // Output packing: {PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, Stall}
    localparam logic [4:0] O_DEF   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00011;
    localparam logic [4:0] O_JUMP  = 5'b11100;
    localparam logic [4:0] O_BR    = 5'b11110;
    localparam logic [4:0] O_RST   = 5'b00110;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pending forced stall cycles and counter values.
    int m_extra = 0;
    int m_stall = 0;
    int m_flush = 0;

    in_t  idle_in;
    vec_t tbl[11];

    function automatic logic [4:0] outs();
        return {PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, Stall};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input int rs, input int rt, input int ur,
                               input int pc, input int exl, input int ext,
                               input int mml, input int mmr, input int br);
        in_t v;
        v.rs = 5'(rs);  v.rt = 5'(rt); v.uses_rt = 1'(ur);
        v.pcsrc = 3'(pc); v.ex_ld = 1'(exl); v.ex_rt = 5'(ext);
        v.mem_ld = 1'(mml); v.mem_rd = 5'(mmr); v.br = 1'(br);
        return v;
    endfunction

    // Pipeline rules: what the hazard unit must demand for this ID cycle.
    task automatic model(input in_t v, input bit rst,
                         output logic [4:0] o, output bit hold_next);
        bit jr, jr_ex, jr_mem, lu;
        hold_next = 0;
        jr     = (v.pcsrc == 3) && (v.rs != 0);
        jr_ex  = jr && v.ex_ld && (v.ex_rt == v.rs);
        jr_mem = jr && v.mem_ld && (v.mem_rd == v.rs);
        lu     = v.ex_ld && (v.ex_rt != 0) &&
                 ((v.ex_rt == v.rs) || (v.uses_rt && v.ex_rt == v.rt));
        if (rst)                       o = O_RST;
        else if (v.br)                 o = O_BR;
        else if (m_extra > 0)          o = O_STALL;
        else if (jr_ex) begin
            o = O_STALL;
            hold_next = 1;
        end
        else if (jr_mem || lu)         o = O_STALL;
        else if (v.pcsrc == 2 || v.pcsrc == 3) o = O_JUMP;
        else                           o = O_DEF;
    endtask

    task automatic apply(input in_t v, input bit rst);
        @(negedge clk);
        reset          = rst;
        IFID_rs        = v.rs;
        IFID_rt        = v.rt;
        IFID_UsesRt    = v.uses_rt;
        ID_PCsrc       = v.pcsrc;
        IDEX_MemRd     = v.ex_ld;
        IDEX_rt        = v.ex_rt;
        EXMEM_MemRd    = v.mem_ld;
        EXMEM_rdes     = v.mem_rd;
        EX_BranchTaken = v.br;
        #1;
    endtask

    // Compare the current cycle against the model, then advance the model
    // across the coming clock edge.
    task automatic check_model(input string tag, input in_t v, input bit rst);
        logic [4:0] e;
        bit hn;
        model(v, rst, e, hn);
        chk({tag, "_out"}, int'(outs()), int'(e));
        chk({tag, "_scnt"}, int'(stall_cnt), m_stall);
        chk({tag, "_fcnt"}, int'(flush_cnt), m_flush);
        if (rst) begin
            m_extra = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (e[0] && m_stall < CMAX) m_stall++;
            if ((e[1] || e[2]) && m_flush < CMAX) m_flush++;
            if (v.br) m_extra = 0;
            else if (m_extra > 0) m_extra--;
            else if (hn) m_extra = 1;
        end
    endtask

    task automatic step(input string tag, input in_t v, input bit rst);
        apply(v, rst);
        check_model(tag, v, rst);
    endtask

    initial begin
        idle_in = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        //                rs rt ur pc exl ext mml mmr br
        tbl[0]  = '{mk(5, 0, 0, 0, 1, 5, 0, 0, 0), O_STALL};
        tbl[1]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0), O_DEF};
        tbl[2]  = '{mk(3, 7, 1, 0, 1, 7, 0, 0, 0), O_STALL};
        tbl[3]  = '{mk(3, 7, 0, 0, 1, 7, 0, 0, 0), O_DEF};
        tbl[4]  = '{mk(8, 0, 0, 3, 1, 8, 0, 0, 0), O_STALL};
        tbl[5]  = '{mk(8, 0, 0, 3, 0, 0, 1, 8, 0), O_STALL};
        tbl[6]  = '{mk(8, 0, 0, 3, 0, 0, 0, 0, 0), O_JUMP};
        tbl[7]  = '{mk(4, 0, 0, 2, 0, 0, 0, 0, 0), O_JUMP};
        tbl[8]  = '{mk(5, 0, 0, 0, 1, 5, 0, 0, 1), O_BR};
        tbl[9]  = '{mk(0, 0, 0, 3, 0, 0, 1, 0, 0), O_JUMP};
        tbl[10] = '{mk(6, 0, 0, 0, 0, 0, 1, 6, 0), O_DEF};

        step("init_rst", idle_in, 1);
        foreach (tbl[k]) begin
            apply(tbl[k].i, 0);
            chk($sformatf("tbl%0d", k), int'(outs()), int'(tbl[k].exp));
            check_model($sformatf("tbl%0d_m", k), tbl[k].i, 0);
            step("tbl_rst", idle_in, 1);
        end

        // load-use bumps stall_cnt 0 -> 1
        apply(tbl[0].i, 0);
        chk("lu_cnt0", int'(stall_cnt), 0);
        check_model("lu", tbl[0].i, 0);
        step("lu_after", idle_in, 0);
        chk("lu_cnt1", int'(stall_cnt), 1);
        step("seqA_rst", idle_in, 1);

        // jr after load in EX: two stalls then the jump flush
        step("jrA1", mk(8, 0, 0, 3, 1, 8, 0, 0, 0), 0);
        chk("jrA1_stall", int'(Stall), 1);
        step("jrA2", mk(8, 0, 0, 3, 0, 0, 1, 8, 0), 0);
        chk("jrA2_stall", int'(Stall), 1);
        apply(mk(8, 0, 0, 3, 0, 0, 0, 0, 0), 0);
        chk("jrA3_out", int'(outs()), int'(O_JUMP));
        chk("jrA3_scnt", int'(stall_cnt), 2);
        check_model("jrA3", mk(8, 0, 0, 3, 0, 0, 0, 0, 0), 0);
        step("seqB_rst", idle_in, 1);

        // taken branch aborts JR_HOLD
        step("jrB1", mk(9, 0, 0, 3, 1, 9, 0, 0, 0), 0);
        apply(mk(9, 0, 0, 3, 0, 0, 1, 9, 1), 0);
        chk("jrB2_out", int'(outs()), int'(O_BR));
        chk("jrB2_fcnt", int'(flush_cnt), 1);
        check_model("jrB2", mk(9, 0, 0, 3, 0, 0, 1, 9, 1), 0);
        apply(idle_in, 0);
        chk("jrB3_out", int'(outs()), int'(O_DEF));
        chk("jrB3_fcnt", int'(flush_cnt), 2);
        check_model("jrB3", idle_in, 0);
        step("seqC_rst", idle_in, 1);

        // saturation of the 4-bit stall counter
        for (int n = 0; n < 15; n++) step("sat_fill", tbl[0].i, 0);
        apply(tbl[0].i, 0);
        chk("sat_full", int'(stall_cnt), 15);
        check_model("sat_more", tbl[0].i, 0);
        step("sat_hold", idle_in, 0);
        chk("sat_hold15", int'(stall_cnt), 15);
        step("seqD_rst", idle_in, 1);

        // reset in the middle of JR_HOLD
        step("rstD1", mk(8, 0, 0, 3, 1, 8, 0, 0, 0), 0);
        apply(idle_in, 1);
        chk("rstD2_out", int'(outs()), int'(O_RST));
        check_model("rstD2", idle_in, 1);
        apply(idle_in, 0);
        chk("rstD3_out", int'(outs()), int'(O_DEF));
        chk("rstD3_scnt", int'(stall_cnt), 0);
        chk("rstD3_fcnt", int'(flush_cnt), 0);
        check_model("rstD3", idle_in, 0);

        // random traffic with a narrow register range to provoke matches
        for (int c = 0; c < 1500; c++) begin
            in_t v;
            bit r;
            v.rs      = 5'($urandom_range(0, 3));
            v.rt      = 5'($urandom_range(0, 3));
            v.uses_rt = 1'($urandom_range(0, 1));
            v.pcsrc   = 3'($urandom_range(0, 4));
            v.ex_ld   = 1'($urandom_range(0, 1));
            v.ex_rt   = 5'($urandom_range(0, 3));
            v.mem_ld  = 1'($urandom_range(0, 1));
            v.mem_rd  = 5'($urandom_range(0, 3));
            v.br      = ($urandom_range(0, 7) == 0);
            r         = ($urandom_range(0, 39) == 0);
            step("rnd", v, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
